// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared width and opcode constants for the registered ALU
package alu_pkg;

  localparam int WIDTH = 16;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MOV = 4'b0011;
  localparam logic [3:0] OP_CMP = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1000;
  localparam logic [3:0] OP_SHL = 4'b1001;
  localparam logic [3:0] OP_SHR = 4'b1010;
  localparam logic [3:0] OP_ASR = 4'b1011;

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - combinational opcode decode and next-value compute for the ALU
module alu_comb #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_cop,
  output logic [WIDTH-1:0] o_result,
  output logic             o_ovf,
  output logic             o_hold
);
  import alu_pkg::*;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [3:0]         w_sh;
  logic [2*WIDTH-1:0] w_shl;

  // One extra bit on add/sub carries the carry-out or the borrow.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_sh   = i_b[3:0];
  // Double-width left shift keeps the bits pushed out of the top for the overflow flag.
  assign w_shl  = {{WIDTH{1'b0}}, i_a} << w_sh;

  // Decode the opcode into the next register value; NOP and reserved codes only raise hold.
  always_comb begin
    o_result = '0;
    o_ovf    = 1'b0;
    o_hold   = 1'b0;
    case (i_cop)
      OP_ADD: {o_ovf, o_result} = w_sum;
      OP_SUB: {o_ovf, o_result} = w_diff;
      OP_MOV: o_result = i_a;
      OP_CMP: o_result = {{(WIDTH-2){1'b0}}, (i_a < i_b), (i_a == i_b)};
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_NOT: o_result = ~i_a;
      OP_SHL: begin
        o_result = w_shl[WIDTH-1:0];
        o_ovf    = |w_shl[2*WIDTH-1:WIDTH];
      end
      OP_SHR: o_result = i_a >> w_sh;
      OP_ASR: o_result = $unsigned($signed(i_a) >>> w_sh);
      default: o_hold = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - 16-bit registered ALU with one-cycle latency and asynchronous reset
module alu #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] reg_A,
  input  logic [WIDTH-1:0] reg_B,
  input  logic [3:0]       cop,
  output logic [WIDTH-1:0] result,
  output logic             OVF
);

  logic [WIDTH-1:0] r_result;
  logic             r_ovf;
  logic [WIDTH-1:0] w_next_result;
  logic             w_next_ovf;
  logic             w_hold;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .i_a      (reg_A),
    .i_b      (reg_B),
    .i_cop    (cop),
    .o_result (w_next_result),
    .o_ovf    (w_next_ovf),
    .o_hold   (w_hold)
  );

  // Output register: cleared at once by reset, otherwise loads unless the opcode says hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else if (!w_hold) begin
      r_result <= w_next_result;
      r_ovf    <= w_next_ovf;
    end
  end

  assign result = r_result;
  assign OVF    = r_ovf;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard testbench for the registered ALU
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] reg_A = 16'h0000;
  logic [15:0] reg_B = 16'h0000;
  logic [3:0]  cop = 4'b0000;
  logic [15:0] result;
  logic        OVF;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  alu dut (
    .clk    (clk),
    .reset  (reset),
    .reg_A  (reg_A),
    .reg_B  (reg_B),
    .cop    (cop),
    .result (result),
    .OVF    (OVF)
  );

  always #5 clk = ~clk;

  // Independent reference: plain integer arithmetic and bit loops.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input exp_t prev);
    exp_t e;
    int   s;
    int   sh;
    e.res = 16'h0000;
    e.ovf = 1'b0;
    sh = int'(b[3:0]);
    case (op)
      4'd1: begin s = int'(a) + int'(b); e.res = s[15:0]; e.ovf = (s > 65535); end
      4'd2: begin s = int'(a) - int'(b); e.res = s[15:0]; e.ovf = (int'(a) < int'(b)); end
      4'd3: e.res = a;
      4'd4: e.res = (int'(a) < int'(b)) ? 16'h0002 : ((a == b) ? 16'h0001 : 16'h0000);
      4'd5: e.res = a & b;
      4'd6: e.res = a | b;
      4'd7: e.res = a ^ b;
      4'd8: e.res = a ^ 16'hFFFF;
      4'd9: begin
        s = int'(a) * (1 << sh);
        e.res = s[15:0];
        e.ovf = (s >= 65536);
      end
      4'd10: e.res = 16'(int'(a) / (1 << sh));
      4'd11: begin
        e.res = a;
        for (int k = 0; k < sh; k++) e.res = {e.res[15], e.res[15:1]};
      end
      default: e = prev;
    endcase
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    reg_A = 16'h1234; reg_B = 16'hFFFF; cop = OP_ADD;
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if (result !== 16'h0000 || OVF !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: got %h/%b expected 0000/0", result, OVF);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    cop = OP_NOP;
    reset = 1'b0;
    e.res = 16'h0000; e.ovf = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if (result !== e.res || OVF !== e.ovf) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d]: got %h/%b expected %h/%b", i, result, OVF, e.res, e.ovf);
      end
    end
  endtask

  task automatic test_add();
    vec_t v[4] = '{'{OP_ADD, 16'h0000, 16'h0001, 16'h0001, 1'b0},
                   '{OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0},
                   '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1},
                   '{OP_ADD, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1}};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      reg_A = v[i].a; reg_B = v[i].b; cop = v[i].op;
      e.res = v[i].res; e.ovf = v[i].ovf;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if (result !== e.res || OVF !== e.ovf) begin
        tests_failed++;
        $display("FAIL add[%0d]: got %h/%b expected %h/%b", i, result, OVF, e.res, e.ovf);
      end
    end
  endtask

  task automatic test_sub();
    vec_t v[4] = '{'{OP_SUB, 16'h0001, 16'h0000, 16'h0001, 1'b0},
                   '{OP_SUB, 16'h0001, 16'h0001, 16'h0000, 1'b0},
                   '{OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b1},
                   '{OP_SUB, 16'h0000, 16'hFFFF, 16'h0001, 1'b1}};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      reg_A = v[i].a; reg_B = v[i].b; cop = v[i].op;
      e.res = v[i].res; e.ovf = v[i].ovf;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if (result !== e.res || OVF !== e.ovf) begin
        tests_failed++;
        $display("FAIL sub[%0d]: got %h/%b expected %h/%b", i, result, OVF, e.res, e.ovf);
      end
    end
  endtask

  task automatic test_mov_cmp();
    vec_t v[4] = '{'{OP_MOV, 16'h0001, 16'h0000, 16'h0001, 1'b0},
                   '{OP_CMP, 16'h0001, 16'h0000, 16'h0000, 1'b0},
                   '{OP_CMP, 16'h0001, 16'h0001, 16'h0001, 1'b0},
                   '{OP_CMP, 16'h0000, 16'h0001, 16'h0002, 1'b0}};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      reg_A = v[i].a; reg_B = v[i].b; cop = v[i].op;
      e.res = v[i].res; e.ovf = v[i].ovf;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if (result !== e.res || OVF !== e.ovf) begin
        tests_failed++;
        $display("FAIL mov_cmp[%0d]: got %h/%b expected %h/%b", i, result, OVF, e.res, e.ovf);
      end
    end
  endtask

  task automatic test_logic_shift();
    vec_t v[9] = '{'{OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0},
                   '{OP_SHL, 16'h8001, 16'h0001, 16'h0002, 1'b1},
                   '{OP_ASR, 16'h8000, 16'h000F, 16'hFFFF, 1'b0},
                   '{OP_SHR, 16'h8000, 16'h000F, 16'h0001, 1'b0},
                   '{OP_OR,  16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0},
                   '{OP_XOR, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0},
                   '{OP_NOT, 16'h00FF, 16'h1234, 16'hFF00, 1'b0},
                   '{OP_SHL, 16'h8001, 16'hFFF0, 16'h8001, 1'b0},
                   '{OP_SHL, 16'h0F00, 16'h0004, 16'hF000, 1'b0}};
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      reg_A = v[i].a; reg_B = v[i].b; cop = v[i].op;
      e.res = v[i].res; e.ovf = v[i].ovf;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if (result !== e.res || OVF !== e.ovf) begin
        tests_failed++;
        $display("FAIL logic_shift[%0d]: got %h/%b expected %h/%b", i, result, OVF, e.res, e.ovf);
      end
    end
  endtask

  task automatic test_nop_reserved();
    logic [3:0] ops[5] = '{4'b0000, 4'b1111, 4'b1100, 4'b1101, 4'b1110};
    exp_t e;
    reg_A = 16'h0001; reg_B = 16'h0001; cop = OP_ADD;
    e.res = 16'h0002; e.ovf = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    tests_run++;
    if (result !== e.res || OVF !== e.ovf) begin
      tests_failed++;
      $display("FAIL nop_setup: got %h/%b expected %h/%b", result, OVF, e.res, e.ovf);
    end
    for (int i = 0; i < 5; i++) begin
      cop = ops[i];
      reg_A = (i == 0) ? 'x : 16'(16'hFFFF - 16'(i));
      reg_B = (i == 0) ? 'x : 16'hFFFF;
      e.res = 16'h0002; e.ovf = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      tests_run++;
      if (result !== e.res || OVF !== e.ovf) begin
        tests_failed++;
        $display("FAIL nop_hold[%0d]: got %h/%b expected %h/%b", i, result, OVF, e.res, e.ovf);
      end
    end
    // Mid-stream reset: queue an in-flight result, then discard it on reset.
    reg_A = 16'hFFFF; reg_B = 16'hFFFF; cop = OP_ADD;
    e.res = 16'hFFFE; e.ovf = 1'b1;
    sb.push_back(e);
    #2 reset = 1'b1;
    sb.delete();
    #1;
    tests_run++;
    if (result !== 16'h0000 || OVF !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got %h/%b expected 0000/0", result, OVF);
    end
    @(posedge clk); #1;
    tests_run++;
    if (result !== 16'h0000 || OVF !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_held: got %h/%b expected 0000/0", result, OVF);
    end
    reset = 1'b0;
    reg_A = 16'h0001; reg_B = 16'h0001;
    e.res = 16'h0002; e.ovf = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    tests_run++;
    if (result !== e.res || OVF !== e.ovf) begin
      tests_failed++;
      $display("FAIL reset_release: got %h/%b expected %h/%b", result, OVF, e.res, e.ovf);
    end
  endtask

  task automatic test_back_to_back();
    exp_t prev;
    exp_t e;
    reg_A = 16'h5A5A; reg_B = 16'h0000; cop = OP_MOV;
    prev.res = 16'h5A5A; prev.ovf = 1'b0;
    sb.push_back(prev);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL b2b_empty[%0d]: got empty scoreboard expected one entry", i);
      end else begin
        e = sb.pop_front();
        tests_run++;
        if (result !== e.res || OVF !== e.ovf) begin
          tests_failed++;
          $display("FAIL b2b[%0d]: got %h/%b expected %h/%b", i, result, OVF, e.res, e.ovf);
        end
        prev = e;
      end
      cop   = 4'($urandom_range(0, 15));
      reg_A = 16'($urandom);
      reg_B = 16'($urandom);
      if (i % 7 == 0) reg_B = reg_A;
      sb.push_back(model(cop, reg_A, reg_B, prev));
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    tests_run++;
    if (result !== e.res || OVF !== e.ovf) begin
      tests_failed++;
      $display("FAIL b2b_last: got %h/%b expected %h/%b", result, OVF, e.res, e.ovf);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mov_cmp();
    test_logic_shift();
    test_nop_reserved();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $fatal(1);
  end

endmodule
